// File: rtl/aer_in_bus_fifo.sv
// Bundled-data req/ack receiver (4-phase or 2-phase) with a synchronised request
// and a FIFO presenting captured words to the core over valid/ready.
module aer_in_bus_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter bit TWO_PHASE   = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          request,
   output logic                          acknowledge,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic {IDLE, HOLD} state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   req_sync;
   state_t                 state_q, state_d;
   logic                   ack_q, ack_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic                   full, push, pop;

   assign sync_d   = {sync_q[SYNC_STAGES-2:0], request};
   assign req_sync = sync_q[SYNC_STAGES-1];

   // Full is judged on the current count, so a same-edge pop never admits a push.
   assign full      = (count_q == FULL_CNT);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;

   always_comb begin
      push    = 1'b0;
      ack_d   = ack_q;
      state_d = state_q;
      if (TWO_PHASE) begin
         // Every mismatch between the synchronised request and our ack is one event.
         if ((req_sync != ack_q) && !full) begin
            push  = 1'b1;
            ack_d = ~ack_q;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (req_sync && !full) begin
                  push    = 1'b1;
                  ack_d   = 1'b1;
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (!req_sync) begin
                  ack_d   = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= '0;
         state_q  <= IDLE;
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         ack_q    <= ack_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage holds no control state, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   assign out_data    = mem_q[rd_ptr_q];
   assign acknowledge = ack_q;
   assign fill_level  = count_q;

endmodule

// File: tb/tb_aer_in_bus_fifo.sv
// Bench for aer_in_bus_fifo: a 4-phase and a 2-phase instance, each tracked by a
// queue model of the stored words plus directed handshake scenarios.
module tb_aer_in_bus_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req  [2];
   logic          ack  [2];
   logic [DW-1:0] din  [2];
   logic [DW-1:0] dout [2];
   logic          vld  [2];
   logic          rdy  [2];
   logic [2:0]    fill [2];

   int checks   = 0;
   int failures = 0;

   logic          rdy_s    [2];
   logic [DW-1:0] din_s    [2];
   logic          ack_prev [2];
   logic [DW-1:0] m_mem    [2][16];
   int            m_head   [2];
   int            m_cnt    [2];
   logic          pop_m, push_m;

   aer_in_bus_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TWO_PHASE(1'b0)) dut4 (
      .clk(clk), .rst(rst), .request(req[0]), .acknowledge(ack[0]), .in_data(din[0]),
      .out_data(dout[0]), .out_valid(vld[0]), .out_ready(rdy[0]), .fill_level(fill[0]));

   aer_in_bus_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TWO_PHASE(1'b1)) dut2 (
      .clk(clk), .rst(rst), .request(req[1]), .acknowledge(ack[1]), .in_data(din[1]),
      .out_data(dout[1]), .out_valid(vld[1]), .out_ready(rdy[1]), .fill_level(fill[1]));

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp_v);
      end
   endtask

   task automatic chk_lat(input string nm, input int n);
      checks++;
      if (n < SYNC || n > SYNC + 1) begin
         failures++;
         $display("FAIL %s latency actual=%0d required=%0d..%0d", nm, n, SYNC, SYNC + 1);
      end
   endtask

   task automatic wait_ack(input int i, input logic lvl, input string nm);
      int n = 0;
      while (ack[i] !== lvl && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk_lat(nm, n);
   endtask

   task automatic hs4(input logic [DW-1:0] w);
      din[0] = w;
      req[0] = 1'b1;
      wait_ack(0, 1'b1, "hs4_rise");
      req[0] = 1'b0;
      wait_ack(0, 1'b0, "hs4_fall");
   endtask

   task automatic drain(input int i);
      int n = 0;
      rdy[i] = 1'b1;
      while (vld[i] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", int'(vld[i]), 0);
      rdy[i] = 1'b0;
   endtask

   // Sample what the DUT sees at each active edge.
   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         rdy_s[i] = rdy[i];
         din_s[i] = din[i];
      end
   end

   // Model update and per-cycle comparison on the falling edge.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_cnt[i]    = 0;
            m_head[i]   = 0;
            ack_prev[i] = 1'b0;
         end else begin
            pop_m  = rdy_s[i] && (m_cnt[i] > 0);
            push_m = (i == 1) ? (ack[i] != ack_prev[i]) : (ack[i] && !ack_prev[i]);
            chk($sformatf("push_while_full%0d", i), int'(push_m && m_cnt[i] == DEPTH), 0);
            if (pop_m) begin
               m_head[i] = (m_head[i] + 1) % 16;
               m_cnt[i]--;
            end
            if (push_m) begin
               m_mem[i][(m_head[i] + m_cnt[i]) % 16] = din_s[i];
               m_cnt[i]++;
            end
            ack_prev[i] = ack[i];
            chk($sformatf("fill%0d", i), int'(fill[i]), m_cnt[i]);
            chk($sformatf("valid%0d", i), int'(vld[i]), int'(m_cnt[i] != 0));
            if (m_cnt[i] != 0)
               chk($sformatf("data%0d", i), int'(dout[i]), int'(m_mem[i][m_head[i]]));
         end
      end
   end

   initial begin
      logic [DW-1:0] t1w [2];
      logic [DW-1:0] t3w [3];
      t1w = '{8'hA5, 8'h3C};
      t3w = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0;
         din[i] = '0;
         rdy[i] = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ack", int'(ack[i]), 0);
         chk("rst_valid", int'(vld[i]), 0);
         chk("rst_fill", int'(fill[i]), 0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // 4-phase, consumer always ready
      rdy[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         din[0] = t1w[k];
         req[0] = 1'b1;
         wait_ack(0, 1'b1, "t1_rise");
         chk("t1_fill", int'(fill[0]), 1);
         chk("t1_data", int'(dout[0]), int'(t1w[k]));
         @(posedge clk); #1;
         chk("t1_valid_one_cycle", int'(vld[0]), 0);
         req[0] = 1'b0;
         wait_ack(0, 1'b0, "t1_fall");
      end

      // 4-phase backpressure
      rdy[0] = 1'b0;
      for (int k = 1; k <= 4; k++) hs4(DW'(k));
      chk("t2_fill_full", int'(fill[0]), 4);
      din[0] = 8'h05;
      req[0] = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      chk("t2_ack_withheld", int'(ack[0]), 0);
      chk("t2_fill_held", int'(fill[0]), 4);
      rdy[0] = 1'b1;
      @(posedge clk); #1;
      rdy[0] = 1'b0;
      chk("t2_fill_after_pop", int'(fill[0]), 3);
      chk("t2_head_after_pop", int'(dout[0]), 8'h02);
      @(posedge clk); #1;
      chk("t2_ack_fifth", int'(ack[0]), 1);
      chk("t2_fill_refilled", int'(fill[0]), 4);
      req[0] = 1'b0;
      wait_ack(0, 1'b0, "t2_fall_fifth");
      drain(0);

      // 2-phase transitions
      for (int k = 0; k < 3; k++) begin
         din[1] = t3w[k];
         req[1] = ~req[1];
         wait_ack(1, req[1], "t3_toggle");
      end
      chk("t3_ack_final", int'(ack[1]), 1);
      chk("t3_fill", int'(fill[1]), 3);
      chk("t3_head0", int'(dout[1]), 8'h11);
      rdy[1] = 1'b1;
      @(posedge clk); #1;
      chk("t3_head1", int'(dout[1]), 8'h22);
      @(posedge clk); #1;
      chk("t3_head2", int'(dout[1]), 8'h33);
      @(posedge clk); #1;
      chk("t3_empty", int'(vld[1]), 0);
      rdy[1] = 1'b0;

      // Same-edge push and pop at level 2, wrapping the pointers
      hs4(8'h21);
      hs4(8'h22);
      for (int k = 0; k < 10; k++) begin
         din[0] = DW'(8'h40 + k);
         req[0] = 1'b1;
         @(posedge clk); #1;
         @(posedge clk); #1;
         rdy[0] = 1'b1;
         @(posedge clk); #1;
         rdy[0] = 1'b0;
         chk("t4_ack", int'(ack[0]), 1);
         chk("t4_fill_steady", int'(fill[0]), 2);
         req[0] = 1'b0;
         wait_ack(0, 1'b0, "t4_fall");
      end
      drain(0);

      // Reset in the middle of a handshake
      hs4(8'h31);
      hs4(8'h32);
      din[0] = 8'h33;
      req[0] = 1'b1;
      wait_ack(0, 1'b1, "t5_rise");
      chk("t5_fill_before", int'(fill[0]), 3);
      rst = 1'b1;
      req[0] = 1'b0;
      req[1] = 1'b0;
      #1;
      chk("t5_ack", int'(ack[0]), 0);
      chk("t5_valid", int'(vld[0]), 0);
      chk("t5_fill", int'(fill[0]), 0);
      chk("t5_ack_2ph", int'(ack[1]), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rdy[0] = 1'b1;
      din[0] = 8'h77;
      req[0] = 1'b1;
      wait_ack(0, 1'b1, "t5_rise_after");
      chk("t5_data_after", int'(dout[0]), 8'h77);
      req[0] = 1'b0;
      wait_ack(0, 1'b0, "t5_fall_after");

      // Pop attempts on an empty FIFO
      repeat (3) begin @(posedge clk); #1; end
      chk("t6_fill", int'(fill[0]), 0);
      chk("t6_valid", int'(vld[0]), 0);
      din[0] = 8'h5A;
      req[0] = 1'b1;
      wait_ack(0, 1'b1, "t6_rise");
      chk("t6_data", int'(dout[0]), 8'h5A);
      req[0] = 1'b0;
      wait_ack(0, 1'b0, "t6_fall");
      rdy[0] = 1'b0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aer_in_bus_fifo.md
Name: aer_in_bus_fifo

Overview:
- Parametrised successor of the single-word high-speed input bus receiver.
- Receives bundled-data words from an asynchronous sender over a req/ack handshake. Supports 4-phase or 2-phase signalling, selected by parameter.
- Synchronises `request` through a configurable number of flip-flop stages and buffers captured words in a FIFO.
- Presents words to the clocked core over a valid/ready interface. When the FIFO is full, the block applies backpressure by withholding `acknowledge`.

Parameters:
- DATA_WIDTH, 8, width of the in_data and out_data words.
- FIFO_DEPTH, 4, number of buffered words. Must be a power of 2 and at least 2.
- SYNC_STAGES, 2, number of synchroniser flip-flops on `request`. Must be at least 2.
- TWO_PHASE, 0, handshake mode. 0 = 4-phase (return-to-zero); 1 = 2-phase (transition signalling).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- request  input  1  sender request, asynchronous to clk.
- acknowledge  output  1  registered acknowledge to the sender.
- in_data  input  DATA_WIDTH  bundled data. The sender keeps it stable from before `request` changes until `acknowledge` responds.
- out_data  output  DATA_WIDTH  word at the FIFO head. Valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head word on a clock edge where out_valid=1.
- fill_level  output  $clog2(FIFO_DEPTH)+1  number of words currently stored, 0..FIFO_DEPTH.

Behaviour:
- Reset (asynchronous), applied immediately:
  - all synchroniser flops = 0;
  - acknowledge = 0;
  - rd_ptr = wr_ptr = 0 and fill_level = 0, so out_valid = 0;
  - FSM = IDLE.
  - out_data is don't-care after reset.
- Synchroniser: req_sync is the output of the SYNC_STAGES-deep flop chain. All handshake decisions use req_sync only.
- full = (fill_level == FIFO_DEPTH). full is evaluated on the current count; a same-cycle pop does not free space for a push.
- 4-phase mode (TWO_PHASE=0), FSM with states IDLE and HOLD:
  - IDLE: if req_sync=1 and !full → push in_data, acknowledge <= 1, go to HOLD. Otherwise stay in IDLE with acknowledge = 0.
  - HOLD: if req_sync=0 → acknowledge <= 0, go to IDLE. No push occurs in HOLD.
  - While full in IDLE with req_sync=1, the block waits and acknowledge stays 0. The capture happens on the first edge where !full.
- 2-phase mode (TWO_PHASE=1):
  - A pending event exists when req_sync != acknowledge.
  - If an event is pending and !full → push in_data and toggle acknowledge (acknowledge <= ~acknowledge).
  - There is one push per request transition.
- Push and acknowledge timing:
  - The push and the acknowledge change occur on the same clock edge.
  - The pushed word is visible at the head, and out_valid rises, on that edge when the FIFO was empty.
  - Latency from a request edge to the acknowledge edge is SYNC_STAGES to SYNC_STAGES+1 clk cycles.
- FIFO:
  - out_data = mem[rd_ptr], driven combinationally from storage.
  - Pop happens when out_valid & out_ready. rd_ptr increments and wraps modulo FIFO_DEPTH; wr_ptr behaves the same on push.
  - Push and pop in the same cycle with 0 < fill_level < FIFO_DEPTH: both occur and fill_level is unchanged.
  - Pop when empty is ignored.
  - Data ordering is strictly FIFO.
  - Overflow is impossible, because a push only occurs when !full.
- Reset in the middle of a handshake: the block returns to the reset state and all buffered words are lost. In 2-phase mode the sender must be reset concurrently so that its request level is 0.

Test Plan:
- 4-phase, DEPTH=4, out_ready=1: send 0xA5, then 0x3C → acknowledge rises SYNC_STAGES to SYNC_STAGES+1 cycles after each request rise and falls after request falls; out_data shows 0xA5, then 0x3C, each with out_valid high for 1 cycle; fill_level never exceeds 1.
- 4-phase, out_ready=0, send 5 words 0x01..0x05 → 4 acks; fill_level=4; the 5th request stays unacknowledged. Raise out_ready for 1 cycle → pop 0x01, the 5th word is captured (acknowledge rises), fill_level=4.
- 2-phase, send request toggles carrying 0x11, 0x22, 0x33 → acknowledge toggles 3 times and ends at 1; the FIFO yields 0x11, 0x22, 0x33 in order.
- Simultaneous push and pop at fill_level=2 → fill_level stays 2 and the pointers wrap correctly across 8+ words.
- Assert rst while in HOLD with fill_level=3 → acknowledge=0, out_valid=0, fill_level=0 immediately. After release, a new handshake works normally.
- Pop attempt with out_ready=1 on an empty FIFO → no pointer change and fill_level stays 0.
